alu_sched: RTL and testbench

ALU_SCHED -- requirements
Module: alu_sched

---
 rtl/alu_pkg.sv | 15 +
 rtl/alu_sched_rr_arb2.sv | 15 +
 rtl/alu_sched.sv | 127 ++++++++++++
 tb/tb_alu_sched.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode constants and FSM state encoding for the ALU scheduler.
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_e;

endpackage

// File: rtl/alu_sched_rr_arb2.sv
// Two-requester round-robin grant: ptr names the requester granted last.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] grant
);

  // One-hot grant; a lone requester always wins, contention goes to the other side of ptr
  always_comb begin
    grant    = 2'b00;
    grant[0] = valid[0] & (~valid[1] | ptr);
    grant[1] = valid[1] & (~valid[0] | ~ptr);
  end

endmodule

// File: rtl/alu_sched.sv
// Schedules two requesters onto one shared combinational ALU and returns
// each result through a single valid/ready response channel.
module alu_sched
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_opcode,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_opcode,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [1:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_result,
  output logic             busy,
  output logic [7:0]       op_count
);

  state_e           state_r;
  state_e           state_s;
  logic             ptr_r;
  logic [1:0]       grant_s;
  logic             accept_s;
  logic [1:0]       opcode_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             id_r;
  logic [WIDTH-1:0] resp_result_r;
  logic             resp_id_r;
  logic [7:0]       op_count_r;

  rr_arb2 u_arb (
    .valid ({req1_valid, req0_valid}),
    .ptr   (ptr_r),
    .grant (grant_s)
  );

  // Next-state and handshake decode
  always_comb begin
    state_s    = state_r;
    accept_s   = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (|grant_s) begin
          accept_s   = 1'b1;
          req0_ready = grant_s[0] & ~rst;
          req1_ready = grant_s[1] & ~rst;
          state_s    = ST_EXEC;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_EXEC: state_s = ST_RESP;
      ST_RESP: begin
        if (resp_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RESP;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand latch, result capture and completion counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r         <= 1'b1;
      opcode_r      <= 2'b00;
      a_r           <= '0;
      b_r           <= '0;
      id_r          <= 1'b0;
      resp_result_r <= '0;
      resp_id_r     <= 1'b0;
      op_count_r    <= 8'd0;
    end else begin
      if (accept_s) begin
        ptr_r    <= grant_s[1];
        id_r     <= grant_s[1];
        opcode_r <= grant_s[1] ? req1_opcode : req0_opcode;
        a_r      <= grant_s[1] ? req1_a : req0_a;
        b_r      <= grant_s[1] ? req1_b : req0_b;
      end
      if (state_r == ST_EXEC) begin
        resp_result_r <= alu_result;
        resp_id_r     <= id_r;
      end
      if ((state_r == ST_RESP) && resp_ready) begin
        op_count_r <= op_count_r + 8'd1;
      end
    end
  end

  assign alu_opcode  = opcode_r;
  assign alu_a       = a_r;
  assign alu_b       = b_r;
  assign resp_valid  = (state_r == ST_RESP);
  assign resp_id     = resp_id_r;
  assign resp_result = resp_result_r;
  assign busy        = (state_r != ST_IDLE);
  assign op_count    = op_count_r;

endmodule

// File: tb/tb_alu_sched.sv
// Self-checking bench for alu_sched: vector table, directed corner cases and
// randomized transactions against a transaction-level reference model.
module tb_alu_sched;

  logic       clk;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [1:0] req0_opcode, req1_opcode;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0] alu_opcode;
  logic [7:0] alu_a, alu_b, alu_result;
  logic       resp_valid, resp_ready, resp_id;
  logic [7:0] resp_result;
  logic       busy;
  logic [7:0] op_count;

  int errors = 0;
  int checks = 0;
  int last   = 1;
  int exp_count = 0;
  int done   = 0;

  typedef struct packed {
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } req_t;

  typedef struct {
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
  } vec_t;

  alu_sched #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .busy(busy), .op_count(op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ref_alu(input logic [1:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
    int r;
    case (op)
      2'd0:    r = int'(a) + int'(b);
      2'd1:    r = int'(a) - int'(b);
      2'd2:    r = int'(a & b);
      default: r = int'(a | b);
    endcase
    return r[7:0];
  endfunction

  // Environment ALU feeding the scheduler
  always_comb alu_result = ref_alu(alu_opcode, alu_a, alu_b);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    last = 1;
    exp_count = 0;
    done = 0;
  endtask

  // One complete transaction; the model decides the winner from the round-robin rule
  task automatic run_txn(input logic v0, input req_t r0, input logic v1, input req_t r1,
                         input logic hold, input int bp, output int win_o);
    int win;
    req_t w;
    logic [7:0] er;
    req0_valid = v0; req0_opcode = r0.op; req0_a = r0.a; req0_b = r0.b;
    req1_valid = v1; req1_opcode = r1.op; req1_a = r1.a; req1_b = r1.b;
    #1;
    if (v0 && v1) win = (last == 1) ? 0 : 1;
    else          win = v1 ? 1 : 0;
    last = win;
    w  = (win == 1) ? r1 : r0;
    er = ref_alu(w.op, w.a, w.b);
    check("idle_busy", busy, 0);
    check("ready0", req0_ready, win == 0);
    check("ready1", req1_ready, win == 1);
    step();
    if (!hold) begin
      if (win == 0) req0_valid = 1'b0;
      else          req1_valid = 1'b0;
    end
    check("exec_busy", busy, 1);
    check("exec_ready", {req1_ready, req0_ready}, 0);
    check("exec_resp_valid", resp_valid, 0);
    check("exec_alu_op", alu_opcode, w.op);
    check("exec_alu_a", alu_a, w.a);
    check("exec_alu_b", alu_b, w.b);
    step();
    for (int i = 0; i < bp; i++) begin
      check("bp_valid", resp_valid, 1);
      check("bp_result", resp_result, er);
      check("bp_id", resp_id, win);
      check("bp_ready", {req1_ready, req0_ready}, 0);
      check("bp_count", op_count, exp_count);
      step();
    end
    check("resp_valid", resp_valid, 1);
    check("resp_result", resp_result, er);
    check("resp_id", resp_id, win);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    exp_count = (exp_count + 1) % 256;
    done++;
    check("op_count", op_count, exp_count);
    check("done_valid", resp_valid, 0);
    check("hold_alu_a", alu_a, w.a);
    win_o = win;
  endtask

  initial begin
    vec_t vecs[6];
    req_t z, ra, rb;
    int w;
    int ids[6];

    vecs[0] = '{2'd0, 8'h05, 8'h03, 8'h08};
    vecs[1] = '{2'd1, 8'h00, 8'h01, 8'hFF};
    vecs[2] = '{2'd0, 8'hFF, 8'h01, 8'h00};
    vecs[3] = '{2'd2, 8'hCC, 8'hAA, 8'h88};
    vecs[4] = '{2'd3, 8'h50, 8'h05, 8'h55};
    vecs[5] = '{2'd1, 8'h10, 8'h01, 8'h0F};
    z = '0;

    rst = 1'b1; resp_ready = 1'b0;
    req0_valid = 1'b1; req0_opcode = 2'd0; req0_a = 8'h00; req0_b = 8'h00;
    req1_valid = 1'b0; req1_opcode = 2'd0; req1_a = 8'h00; req1_b = 8'h00;
    #2;
    check("rst_ready0", req0_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_outputs", {resp_result, resp_id, alu_opcode, alu_a, alu_b}, 0);
    check("rst_count", op_count, 0);
    req0_valid = 1'b0;
    do_reset();

    // Single request, then contention straight after reset
    run_txn(1'b1, '{2'd0, 8'h05, 8'h03}, 1'b0, z, 1'b0, 0, w);
    check("single_result", resp_result, 8'h08);
    do_reset();
    ra = '{2'd1, 8'h10, 8'h01};
    rb = '{2'd3, 8'hF0, 8'h0F};
    run_txn(1'b1, ra, 1'b1, rb, 1'b0, 0, w);
    check("cont_first_id", w, 0);
    check("cont_first_res", resp_result, 8'h0F);
    run_txn(1'b0, ra, 1'b1, rb, 1'b0, 0, w);
    check("cont_second_id", w, 1);
    check("cont_second_res", resp_result, 8'hFF);

    // Fairness with both held valid
    for (int i = 0; i < 6; i++) begin
      run_txn(1'b1, ra, 1'b1, rb, 1'b1, 0, ids[i]);
    end
    for (int i = 0; i < 6; i++) check("fair_seq", ids[i], i % 2);

    // Backpressure with a competing request waiting
    run_txn(1'b1, ra, 1'b1, rb, 1'b0, 5, w);

    // Vector table on both requesters
    for (int i = 0; i < 6; i++) begin
      ra = '{vecs[i].op, vecs[i].a, vecs[i].b};
      run_txn(i % 2 == 0, ra, i % 2 == 1, ra, 1'b0, 0, w);
      check("vec_result", resp_result, vecs[i].exp);
    end

    // Random traffic up to 256 completions since reset
    while (done < 256) begin
      logic v0, v1;
      v0 = 1'($urandom_range(0, 1));
      v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
      ra = req_t'($urandom);
      rb = req_t'($urandom);
      run_txn(v0, ra, v1, rb, 1'b0, int'($urandom_range(0, 2)), w);
    end
    check("wrap_count", op_count, 0);

    // Reset during EXEC abandons the operation
    req0_valid = 1'b1; req0_opcode = 2'd0; req0_a = 8'h21; req0_b = 8'h12;
    step();
    req0_valid = 1'b0;
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("rstx_busy", busy, 0);
    check("rstx_resp_valid", resp_valid, 0);
    check("rstx_count", op_count, 0);
    check("rstx_alu_a", alu_a, 0);
    step();
    rst = 1'b0;
    last = 1;
    exp_count = 0;
    step();
    check("rstx_idle_valid", resp_valid, 0);
    check("rstx_idle_count", op_count, 0);
    run_txn(1'b1, '{2'd0, 8'h21, 8'h12}, 1'b0, z, 1'b0, 0, w);
    check("reissue_result", resp_result, 8'h33);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
